cache_assoc: RTL and testbench

- Parametrised N-way set-associative, write-back data cache between the CPU load/store port and the burst RAM controller (64-bit words, 4-beat bursts).
- Successor to the direct-mapped cache; adds configurable associativity (1, 2 or 4 ways), per-set round-robin replacement and byte-masked writes, with dirty-line write-back on eviction.
- Same CPU-side and br_-side port protocol, so it drops into the existing SoC and bench wiring.

---
 rtl/cache_assoc.sv | 204 ++++++++++++++++++++
 tb/tb_cache_assoc.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc.sv
// ============================================================================
// cache_assoc : N-way set-associative write-back data cache, 64-bit x4 bursts
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_assoc #(
  parameter int Ways               = 2,
  parameter int LineIndexBitWidth  = 2,
  parameter int RamAddressBitWidth = 10,
  parameter int RamAddressingMode  = 3,
  parameter int BurstDataCount     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [31:0]                   address,
  input  logic [31:0]                   data_in,
  input  logic [3:0]                    write_enable,
  output logic [31:0]                   data_out,
  output logic                          data_out_ready,
  output logic                          busy,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RamAddressBitWidth-1:0] br_addr,
  output logic [63:0]                   br_wr_data,
  output logic [7:0]                    br_data_mask,
  input  logic [63:0]                   br_rd_data,
  input  logic                          br_rd_data_valid
);

  localparam int c_SETS   = 1 << LineIndexBitWidth;
  localparam int c_BEAT_W = $clog2(BurstDataCount);
  localparam int c_LINE_W = 64 * BurstDataCount;
  localparam int c_TAG_W  = RamAddressBitWidth + RamAddressingMode - 5 - LineIndexBitWidth;
  localparam int c_WAY_W  = (Ways > 1) ? $clog2(Ways) : 1;
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BurstDataCount - 1);
  localparam logic [c_WAY_W-1:0]  c_LAST_WAY  = c_WAY_W'(Ways - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WB_ISSUE = 3'd1,
    S_WB_DATA  = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4
  } state_t;

  state_t r_state, w_state_next;

  logic [Ways-1:0]     r_valid [c_SETS];
  logic [Ways-1:0]     r_dirty [c_SETS];
  logic [c_WAY_W-1:0]  r_ptr   [c_SETS];
  logic [c_TAG_W-1:0]  r_tag   [c_SETS][Ways];
  logic [c_LINE_W-1:0] r_line  [c_SETS][Ways];

  logic [c_WAY_W-1:0]  r_victim;
  logic [c_BEAT_W-1:0] r_beat;

  logic [2:0]                   w_word;
  logic [LineIndexBitWidth-1:0] w_set;
  logic [c_TAG_W-1:0]           w_tag;
  logic                         w_req;
  logic                         w_hit;
  logic [c_WAY_W-1:0]           w_hit_way;
  logic [c_WAY_W-1:0]           w_victim;
  logic [c_WAY_W-1:0]           w_ptr_next;
  logic [c_LINE_W-1:0]          w_hit_line;
  logic [c_LINE_W-1:0]          w_wb_line;
  logic                         w_unused;

  assign w_word   = address[4:2];
  assign w_set    = address[5 +: LineIndexBitWidth];
  assign w_tag    = address[RamAddressBitWidth+RamAddressingMode-1 -: c_TAG_W];
  assign w_unused = &{1'b0, address[1:0], address[31:RamAddressBitWidth+RamAddressingMode]};

  // Outputs stay quiet while reset is held even if a request is presented.
  assign w_req = enable & rst_n;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < Ways; w++) begin
      if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = c_WAY_W'(w);
      end
    end
  end

  always_comb begin
    w_victim = r_ptr[w_set];
    for (int w = Ways - 1; w >= 0; w--) begin
      if (!r_valid[w_set][w]) w_victim = c_WAY_W'(w);
    end
  end

  assign w_ptr_next   = (r_ptr[w_set] == c_LAST_WAY) ? '0 : r_ptr[w_set] + c_WAY_W'(1);
  assign w_hit_line   = r_line[w_set][w_hit_way];
  assign w_wb_line    = r_line[w_set][r_victim];
  assign data_out     = w_hit_line[{w_word, 5'd0} +: 32];
  assign br_data_mask = 8'd0;

  always_comb begin
    w_state_next   = r_state;
    busy           = 1'b0;
    data_out_ready = 1'b0;
    br_cmd         = 1'b0;
    br_cmd_en      = 1'b0;
    br_addr        = '0;
    br_wr_data     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            data_out_ready = (write_enable == 4'b0000);
          end else begin
            busy         = 1'b1;
            w_state_next = (r_valid[w_set][w_victim] && r_dirty[w_set][w_victim])
                           ? S_WB_ISSUE : S_RD_ISSUE;
          end
        end
      end
      S_WB_ISSUE: begin
        busy         = 1'b1;
        br_cmd       = 1'b1;
        br_cmd_en    = 1'b1;
        br_addr      = {r_tag[w_set][r_victim], w_set, {c_BEAT_W{1'b0}}};
        br_wr_data   = w_wb_line[{r_beat, 6'd0} +: 64];
        w_state_next = S_WB_DATA;
      end
      S_WB_DATA: begin
        busy       = 1'b1;
        br_cmd     = 1'b1;
        br_addr    = {r_tag[w_set][r_victim], w_set, {c_BEAT_W{1'b0}}};
        br_wr_data = w_wb_line[{r_beat, 6'd0} +: 64];
        if (r_beat == c_LAST_BEAT) w_state_next = S_RD_ISSUE;
      end
      S_RD_ISSUE: begin
        busy         = 1'b1;
        br_cmd_en    = 1'b1;
        br_addr      = {w_tag, w_set, {c_BEAT_W{1'b0}}};
        w_state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        busy = 1'b1;
        if (br_rd_data_valid && (r_beat == c_LAST_BEAT)) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_victim <= '0;
      for (int s = 0; s < c_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          r_victim <= w_victim;
          r_beat   <= '0;
          if (w_req && w_hit && (write_enable != 4'b0000)) r_dirty[w_set][w_hit_way] <= 1'b1;
        end
        S_WB_ISSUE: r_beat <= c_BEAT_W'(1);
        // Wraps back to zero on the last beat, ready for the refill.
        S_WB_DATA:  r_beat <= r_beat + c_BEAT_W'(1);
        S_RD_WAIT: begin
          if (br_rd_data_valid) begin
            r_beat <= r_beat + c_BEAT_W'(1);
            if (r_beat == c_LAST_BEAT) begin
              r_valid[w_set][r_victim] <= 1'b1;
              r_dirty[w_set][r_victim] <= 1'b0;
              r_ptr[w_set]             <= w_ptr_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line data and tags need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && w_req && w_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (write_enable[b])
          r_line[w_set][w_hit_way][{w_word, 2'(b), 3'd0} +: 8] <= data_in[b*8 +: 8];
      end
    end
    if ((r_state == S_RD_WAIT) && br_rd_data_valid) begin
      r_line[w_set][r_victim][{r_beat, 6'd0} +: 64] <= br_rd_data;
      if (r_beat == c_LAST_BEAT) r_tag[w_set][r_victim] <= w_tag;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_assoc.sv
// ============================================================================
// tb_cache_assoc : directed self-checking bench with a burst RAM model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cache_assoc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  write_enable = '0;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;
  logic        br_cmd;
  logic        br_cmd_en;
  logic [9:0]  br_addr;
  logic [63:0] br_wr_data;
  logic [7:0]  br_data_mask;
  logic [63:0] br_rd_data = '0;
  logic        br_rd_data_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  cache_assoc dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .address(address),
    .data_in(data_in), .write_enable(write_enable), .data_out(data_out),
    .data_out_ready(data_out_ready), .busy(busy), .br_cmd(br_cmd),
    .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
    .br_rd_data_valid(br_rd_data_valid)
  );

  always #5 clk = ~clk;

  // Burst RAM model: word w (byte 4w) initially holds value w.
  logic [63:0] mem [0:1023];
  int          rd_count = 0, wb_count = 0;
  logic [9:0]  rd_addr_last = '0;
  logic [9:0]  wb_q[$];
  int          rd_cnt = 0, wr_cnt = 0, rd_delay = 0;
  int          rd_base = 0, wr_base = 0;

  always @(negedge clk) begin
    br_rd_data_valid = 1'b0;
    if (!rst_n) begin
      rd_cnt = 0; wr_cnt = 0; rd_delay = 0;
    end else begin
      if (wr_cnt > 0) begin
        mem[wr_base + 4 - wr_cnt] = br_wr_data;
        wr_cnt--;
      end
      if (rd_delay > 0) rd_delay--;
      else if (rd_cnt > 0) begin
        br_rd_data_valid = 1'b1;
        br_rd_data = mem[rd_base + 4 - rd_cnt];
        rd_cnt--;
      end
      if (br_cmd_en) begin
        if (br_cmd) begin
          wr_base = int'(br_addr);
          mem[br_addr] = br_wr_data;
          wr_cnt = 3;
          wb_count++;
          wb_q.push_back(br_addr);
        end else begin
          rd_base = int'(br_addr);
          rd_cnt = 4;
          rd_delay = 1;
          rd_count++;
          rd_addr_last = br_addr;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk);
    enable = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one request and holds it until accepted; cyc = busy cycles seen.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                        output logic [31:0] rd, output logic rdy, output int cyc);
    @(negedge clk);
    address = a; data_in = d; write_enable = we; enable = 1'b1;
    cyc = 0;
    #1;
    while (busy && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    rd = data_out;
    rdy = data_out_ready;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    address = 32'h40;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, data_out_ready, br_cmd_en, br_cmd} !== 4'b0000)
      $display("FAIL reset_outputs: got %b required 0000", {busy, data_out_ready, br_cmd_en, br_cmd});
    checks++;
    if (br_data_mask !== 8'h00)
      $display("FAIL reset_mask: got %h required 00", br_data_mask);
    if ({busy, data_out_ready, br_cmd_en, br_cmd} !== 4'b0000 || br_data_mask !== 8'h00)
      failures++;
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_miss();
    logic [31:0] rd; logic rdy; int cyc; int r0, w0;
    r0 = rd_count; w0 = wb_count;
    access(32'h000, 32'h0, 4'h0, rd, rdy, cyc);
    checks++;
    if (cyc == 0 || cyc >= 300) begin failures++; $display("FAIL miss_busy: busy cycles %0d required 1..299", cyc); end
    checks++;
    if (rd_count - r0 != 1 || rd_addr_last !== 10'd0 || wb_count != w0) begin
      failures++;
      $display("FAIL miss_cmd: reads %0d addr %h writes %0d required 1 000 0", rd_count - r0, rd_addr_last, wb_count - w0);
    end
    checks++;
    if (rdy !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL miss_data: rdy %b data %h required 1 00000000", rdy, rd); end
    r0 = rd_count;
    access(32'h01c, 32'h0, 4'h0, rd, rdy, cyc);
    checks++;
    if (cyc != 0 || rdy !== 1'b1 || rd !== 32'd7 || rd_count != r0) begin
      failures++;
      $display("FAIL hit_word7: cyc %0d rdy %b data %h required 0 1 00000007", cyc, rdy, rd);
    end
  endtask

  task automatic test_write_then_read();
    logic [31:0] rd; logic rdy; int cyc;
    access(32'h004, 32'habcd_1234, 4'hf, rd, rdy, cyc);
    checks++;
    if (cyc != 0 || rdy !== 1'b0) begin failures++; $display("FAIL write_hit: cyc %0d rdy %b required 0 0", cyc, rdy); end
    access(32'h004, 32'h0, 4'h0, rd, rdy, cyc);
    checks++;
    if (cyc != 0 || rdy !== 1'b1 || rd !== 32'habcd_1234) begin
      failures++;
      $display("FAIL read_after_write: cyc %0d rdy %b data %h required 0 1 abcd1234", cyc, rdy, rd);
    end
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd; logic rdy; int cyc;
    access(32'h004, 32'habcd_1234, 4'hf, rd, rdy, cyc);
    access(32'h004, 32'h0000_ff00, 4'b0010, rd, rdy, cyc);
    access(32'h004, 32'h0, 4'h0, rd, rdy, cyc);
    checks++;
    if (rdy !== 1'b1 || rd !== 32'habcd_ff34) begin
      failures++;
      $display("FAIL byte_mask: rdy %b data %h required 1 abcdff34", rdy, rd);
    end
  endtask

  task automatic test_replacement();
    logic [31:0] rd; logic rdy; int cyc; int r0, w0;
    apply_reset();
    wb_q.delete();
    access(32'h000, 32'h11, 4'hf, rd, rdy, cyc);
    access(32'h080, 32'h22, 4'hf, rd, rdy, cyc);
    r0 = rd_count; w0 = wb_count;
    access(32'h000, 32'h0, 4'h0, rd, rdy, cyc);
    checks++;
    if (cyc != 0 || rd !== 32'h11) begin failures++; $display("FAIL rr_hit0: cyc %0d data %h required 0 00000011", cyc, rd); end
    access(32'h080, 32'h0, 4'h0, rd, rdy, cyc);
    checks++;
    if (cyc != 0 || rd !== 32'h22 || rd_count != r0 || wb_count != w0) begin
      failures++;
      $display("FAIL rr_hit1: cyc %0d data %h cmds %0d required 0 00000022 0", cyc, rd, rd_count - r0 + wb_count - w0);
    end
    access(32'h100, 32'h0, 4'h0, rd, rdy, cyc);
    checks++;
    if (wb_q.size() != 1 || wb_q[0] !== 10'h000 || rd_addr_last !== 10'h020 || rd !== 32'h40) begin
      failures++;
      $display("FAIL rr_evict0: wbs %0d rd_addr %h data %h required 1 wb@000 020 00000040", wb_q.size(), rd_addr_last, rd);
    end
    wb_q.delete();
    r0 = rd_count;
    access(32'h080, 32'h0, 4'h0, rd, rdy, cyc);
    checks++;
    if (cyc != 0 || rd !== 32'h22 || rd_count != r0) begin
      failures++;
      $display("FAIL rr_survivor: cyc %0d data %h required 0 00000022", cyc, rd);
    end
    access(32'h000, 32'h0, 4'h0, rd, rdy, cyc);
    checks++;
    if (wb_q.size() != 1 || wb_q[0] !== 10'h010 || rd !== 32'h11) begin
      failures++;
      $display("FAIL rr_evict1: wbs %0d data %h required 1 wb@010 00000011", wb_q.size(), rd);
    end
    wb_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] rd; logic rdy; int cyc; int r0, beats, n;
    @(negedge clk);
    address = 32'h200; data_in = '0; write_enable = 4'h0; enable = 1'b1;
    beats = 0; n = 0;
    while (beats < 3 && n < 100) begin
      @(negedge clk);
      #1;
      if (br_rd_data_valid) beats++;
      n++;
    end
    checks++;
    if (beats != 3) begin failures++; $display("FAIL midburst_beats: got %0d required 3", beats); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || br_cmd_en !== 1'b0) begin
      failures++;
      $display("FAIL midburst_reset: busy %b cmd_en %b required 0 0", busy, br_cmd_en);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = rd_count;
    access(32'h200, 32'h0, 4'h0, rd, rdy, cyc);
    checks++;
    if (cyc == 0 || rd_count - r0 != 1 || rd_addr_last !== 10'h040 || rd !== 32'h80) begin
      failures++;
      $display("FAIL midburst_refetch: cyc %0d reads %0d addr %h data %h required >0 1 040 00000080", cyc, rd_count - r0, rd_addr_last, rd);
    end
  endtask

  task automatic test_fill_all();
    logic [31:0] rd; logic rdy; int cyc; int w0, bad;
    logic [9:0] exp_wb;
    apply_reset();
    wb_q.delete();
    w0 = wb_count;
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      access(32'(4 * i), 32'(i), 4'hf, rd, rdy, cyc);
      exp_wb = 10'((((i / 8) * 4) - 32) & 1023);
      while (wb_q.size() > 0) begin
        checks++;
        if (wb_q[0] !== exp_wb) begin
          failures++;
          $display("FAIL fill_wb_addr: write %0d got %h required %h", i, wb_q[0], exp_wb);
        end
        void'(wb_q.pop_front());
      end
      if (cyc >= 300) bad++;
    end
    checks++;
    if (wb_count - w0 != 248 || bad != 0) begin
      failures++;
      $display("FAIL fill_wb_count: got %0d timeouts %0d required 248 0", wb_count - w0, bad);
    end
    w0 = wb_count;
    for (int i = 0; i < 2048; i++) begin
      access(32'(4 * i), 32'h0, 4'h0, rd, rdy, cyc);
      exp_wb = 10'((((i / 8) * 4) - 32) & 1023);
      while (wb_q.size() > 0) begin
        checks++;
        if (wb_q[0] !== exp_wb) begin
          failures++;
          $display("FAIL read_wb_addr: read %0d got %h required %h", i, wb_q[0], exp_wb);
        end
        void'(wb_q.pop_front());
      end
      checks++;
      if (rdy !== 1'b1 || rd !== 32'(i) || cyc >= 300) begin
        failures++;
        $display("FAIL readback: addr %h rdy %b got %h required %h", 4 * i, rdy, rd, i);
      end
    end
    checks++;
    if (wb_count - w0 != 8) begin
      failures++;
      $display("FAIL read_wb_count: got %0d required 8", wb_count - w0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {32'(2 * i + 1), 32'(2 * i)};
    test_reset();
    test_first_miss();
    test_write_then_read();
    test_byte_mask();
    test_replacement();
    test_reset_mid_burst();
    test_fill_all();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
